button_conditioner: RTL and testbench

Conditions the two raw push-button inputs `b0_in`/`b1_in` and sits directly upstream of the combination-lock stage. It debounces each button and converts each accepted press into a single-cycle code-bit event (`bit_valid`/`bit_value`). It also rejects overlapping presses so that the lock sees exactly one bit per physical press. Output stays in the `clk` domain; the lock consumes `bit_valid` as its only advance strobe.

---
 rtl/button_pkg.sv | 11 +
 rtl/button_conditioner_debounce.sv | 47 ++++
 rtl/button_conditioner.sv | 68 ++++++
 tb/tb_button_conditioner.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// button_pkg: shared FSM states, code-bit values and default debounce length for button_conditioner
package button_pkg;
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_HELD     = 2'd1,
    ST_CONFLICT = 2'd2
  } state_t;
  localparam logic BIT_B0 = 1'b0;
  localparam logic BIT_B1 = 1'b1;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
endpackage

// File: rtl/button_conditioner_debounce.sv
// debounce: one button channel (optional BUTTON_COND_SYNC_EN synchronizer), debounced level and rise detect
module debounce
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic level_q, level_d, prev_q, prev_d, s;
`ifdef BUTTON_COND_SYNC_EN
  logic [1:0] sync_q, sync_d;
  assign sync_d = {sync_q[0], din};
  assign s = sync_q[1];
  always_ff @(posedge clk or negedge reset)
    if (!reset) sync_q <= '0;
    else sync_q <= sync_d;
`else
  assign s = din;
`endif
  always_comb begin
    cnt_d = '0;
    level_d = level_q;
    prev_d = level_q;
    if (s != level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) level_d = ~level_q;
      else cnt_d = cnt_q + CNT_W'(1);
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt_q <= '0;
      level_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      level_q <= level_d;
      prev_q <= prev_d;
    end
  assign level = level_q;
  assign rise = level_q & ~prev_q;
endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: two debounced buttons -> one code-bit strobe per press, overlaps flagged (BUTTON_COND_SYNC_EN adds input sync)
module button_conditioner
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic b0_in,
  input  logic b1_in,
  output logic b0_level,
  output logic b1_level,
  output logic bit_valid,
  output logic bit_value,
  output logic conflict
);
  state_t state_q, state_d;
  logic bit_valid_q, bit_valid_d, bit_value_q, bit_value_d, conflict_q, conflict_d;
  logic rise_0, rise_1, both_low;
  debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_b0 (
    .clk(clk), .reset(reset), .din(b0_in), .level(b0_level), .rise(rise_0)
  );
  debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_b1 (
    .clk(clk), .reset(reset), .din(b1_in), .level(b1_level), .rise(rise_1)
  );
  assign both_low = ~b0_level & ~b1_level;
  always_comb begin
    state_d = state_q;
    bit_valid_d = 1'b0;
    bit_value_d = bit_value_q;
    conflict_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rise_0 & rise_1) begin
          conflict_d = 1'b1;
          state_d = ST_CONFLICT;
        end else if (rise_0 | rise_1) begin
          bit_valid_d = 1'b1;
          bit_value_d = rise_1 ? BIT_B1 : BIT_B0;
          state_d = ST_HELD;
        end
      end
      ST_HELD: begin
        if (rise_0 | rise_1) begin
          conflict_d = 1'b1;
          state_d = ST_CONFLICT;
        end else if (both_low) state_d = ST_IDLE;
      end
      ST_CONFLICT: state_d = both_low ? ST_IDLE : ST_CONFLICT;
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= ST_IDLE;
      bit_valid_q <= 1'b0;
      bit_value_q <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_valid_q <= bit_valid_d;
      bit_value_q <= bit_value_d;
      conflict_q <= conflict_d;
    end
  assign bit_valid = bit_valid_q;
  assign bit_value = bit_value_q;
  assign conflict = conflict_q;
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: scoreboard bench with a sample-window reference model of both channels and the press arbiter
module tb_button_conditioner;
  localparam int DC = 4;
`ifdef BUTTON_COND_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif
  logic clk, reset, b0_in, b1_in;
  logic b0_level, b1_level, bit_valid, bit_value, conflict;

  button_conditioner #(.DEBOUNCE_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .b0_in(b0_in), .b1_in(b1_in),
    .b0_level(b0_level), .b1_level(b1_level),
    .bit_valid(bit_valid), .bit_value(bit_value), .conflict(conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {int cyc; bit conf; bit val;} ev_t;
  ev_t exp_q[$];
  int checks = 0, errors = 0;
  int cycle = 0;
  int n_valid = 0, n_conf = 0;
  bit seen[$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, exp, cycle);
    end
  endtask

  // Reference: a level flips once the last DC samples all disagree with it;
  // an accepted press needs an idle arbiter and exactly one new press.
  bit dly[2][$];
  bit hist[2][$];
  bit lvl[2], lvl_prev[2];
  bit held_val;
  int mode;  // 0 waiting for a press, 1 one press accepted, 2 overlap seen

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      exp_q.delete();
      for (int c = 0; c < 2; c++) begin
        dly[c].delete();
        hist[c].delete();
        for (int i = 0; i < SYNC; i++) dly[c].push_back(1'b0);
        lvl[c] = 1'b0;
        lvl_prev[c] = 1'b0;
      end
      held_val = 1'b0;
      mode = 0;
    end else begin
      bit r0, r1;
      cycle++;
      r0 = lvl[0] && !lvl_prev[0];
      r1 = lvl[1] && !lvl_prev[1];
      if (mode == 0) begin
        if (r0 && r1) begin
          exp_q.push_back('{cycle, 1'b1, held_val});
          mode = 2;
        end else if (r0 || r1) begin
          held_val = r1;
          exp_q.push_back('{cycle, 1'b0, r1});
          mode = 1;
        end
      end else if (mode == 1 && (r0 || r1)) begin
        exp_q.push_back('{cycle, 1'b1, held_val});
        mode = 2;
      end else if (!lvl[0] && !lvl[1]) mode = 0;
      for (int c = 0; c < 2; c++) begin
        bit s;
        int agree;
        dly[c].push_back(c == 0 ? b0_in : b1_in);
        s = dly[c].pop_front();
        lvl_prev[c] = lvl[c];
        hist[c].push_back(s);
        if (hist[c].size() > DC) void'(hist[c].pop_front());
        agree = 0;
        foreach (hist[c][i]) if (hist[c][i] != lvl[c]) agree++;
        if (agree == DC) lvl[c] = !lvl[c];
      end
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      if (bit_valid || conflict) begin
        if (bit_valid) begin
          n_valid++;
          seen.push_back(bit_value);
        end
        if (conflict) n_conf++;
        if (exp_q.size() == 0) chk("unexpected_strobe", {bit_valid, conflict}, 2'b00);
        else begin
          ev_t e;
          e = exp_q.pop_front();
          chk("strobe_cycle", cycle, e.cyc);
          chk("strobe_kind", {bit_valid, conflict}, e.conf ? 2'b01 : 2'b10);
          if (!e.conf) chk("strobe_value", bit_value, e.val);
        end
      end else if (exp_q.size() != 0 && exp_q[0].cyc <= cycle) begin
        chk("missed_strobe_cycle", 0, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
      chk("b0_level", b0_level, lvl[0]);
      chk("b1_level", b1_level, lvl[1]);
      chk("bit_value_hold", bit_value, held_val);
    end
  end

  task automatic wait_cyc(int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  task automatic press(int ch, int hi, int lo);
    if (ch == 0) b0_in = 1'b1; else b1_in = 1'b1;
    wait_cyc(hi);
    if (ch == 0) b0_in = 1'b0; else b1_in = 1'b0;
    wait_cyc(lo);
  endtask

  task automatic chk_all_zero(string name);
    chk(name, {b0_level, b1_level, bit_valid, bit_value, conflict}, 5'b0);
  endtask

  initial begin
    int v0, c0;
    logic [6:0] pat;
    reset = 1'b0;
    b0_in = 1'b0;
    b1_in = 1'b0;
    #103;
    chk_all_zero("reset_outputs");
    reset = 1'b1;
    #1;
    chk_all_zero("post_reset_outputs");
    wait_cyc(3);
    // single press of b0
    v0 = n_valid;
    press(0, 10, 10);
    chk("single_press_strobes", n_valid - v0, 1);
    chk("single_press_value", seen[seen.size()-1], 0);
    // short glitch
    v0 = n_valid; c0 = n_conf;
    press(0, 2, 10);
    chk("glitch_no_output", (n_valid - v0) + (n_conf - c0), 0);
    // code sequence 0110110
    seen.delete();
    pat = 7'b0110110;
    for (int i = 6; i >= 0; i--) press(int'(pat[i]), 20, 20);
    chk("seq_count", seen.size(), 7);
    if (seen.size() == 7) chk("seq_bits", {seen[0], seen[1], seen[2], seen[3], seen[4], seen[5], seen[6]}, pat);
    // simultaneous press
    v0 = n_valid; c0 = n_conf;
    b0_in = 1'b1; b1_in = 1'b1;
    wait_cyc(10);
    b0_in = 1'b0; b1_in = 1'b0;
    wait_cyc(15);
    chk("simul_conflicts", n_conf - c0, 1);
    chk("simul_no_bit", n_valid - v0, 0);
    press(1, 10, 15);
    chk("after_conflict_accept", n_valid - v0, 1);
    // overlapping press inside a long b0 press
    v0 = n_valid; c0 = n_conf;
    b0_in = 1'b1;
    wait_cyc(15);
    press(1, 10, 25);
    b0_in = 1'b0;
    wait_cyc(15);
    chk("overlap_bits", n_valid - v0, 1);
    chk("overlap_conflicts", n_conf - c0, 1);
    // reset pulsed during a held press
    b0_in = 1'b1;
    wait_cyc(12);
    #1 reset = 1'b0;
    #1 chk_all_zero("reset_mid_press");
    v0 = n_valid;
    #2 reset = 1'b1;
    wait_cyc(12);
    chk("held_after_reset_bit", n_valid - v0, 1);
    b0_in = 1'b0;
    wait_cyc(12);
    // random presses, overlaps and bounces
    for (int it = 0; it < 250; it++) begin
      case ($urandom_range(0, 3))
        0: press(0, $urandom_range(1, 12), $urandom_range(0, 12));
        1: press(1, $urandom_range(1, 12), $urandom_range(0, 12));
        2: begin
          b0_in = 1'b1;
          wait_cyc($urandom_range(0, 3));
          b1_in = 1'b1;
          wait_cyc($urandom_range(1, 10));
          b0_in = 1'b0; b1_in = 1'b0;
          wait_cyc($urandom_range(0, 12));
        end
        default: begin
          for (int j = 0; j < 6; j++) begin
            b0_in = 1'($urandom);
            b1_in = 1'($urandom);
            wait_cyc($urandom_range(1, 3));
          end
          b0_in = 1'b0; b1_in = 1'b0;
          wait_cyc($urandom_range(0, 10));
        end
      endcase
    end
    wait_cyc(30);
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
